// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: credit-gated round-robin egress of user streams into BFT packets
module leaf_out_arbiter #(
  parameter int PACKET_BITS           = 49,
  parameter int PAYLOAD_BITS          = 32,
  parameter int NUM_LEAF_BITS         = 5,
  parameter int NUM_PORT_BITS         = 4,
  parameter int NUM_ADDR_BITS         = 7,
  parameter int NUM_OUT_PORTS         = 2,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]                  din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]                               vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]                               ack_interface2user,
  input  logic [NUM_OUT_PORTS*(NUM_LEAF_BITS+NUM_PORT_BITS)-1:0] dest_cfg,
  input  logic [NUM_OUT_PORTS-1:0]                               credit_ret,
  input  logic                                                   out_ready,
  input  logic                                                   resend,
  output logic [PACKET_BITS-1:0]                                 dout_leaf_interface2bft,
  output logic [NUM_OUT_PORTS*(NUM_BRAM_ADDR_BITS+1)-1:0]        credit_cnt
);
  localparam int DW = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int CW = NUM_BRAM_ADDR_BITS + 1;
  localparam int IW = NUM_OUT_PORTS > 1 ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [CW-1:0] CMAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

  logic [PAYLOAD_BITS-1:0]  payload [NUM_OUT_PORTS];
  logic [DW-1:0]            dest [NUM_OUT_PORTS];
  logic [CW-1:0]            credit [NUM_OUT_PORTS];
  logic [CW-1:0]            credit_nxt [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] seq [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0] elig;
  logic [IW-1:0]            last, gnt;
  logic                     found, accept, out_vld;
  logic [PACKET_BITS-2:0]   out_reg;

  for (genvar g = 0; g < NUM_OUT_PORTS; g++) begin : g_port
    assign payload[g] = din_leaf_user2interface[g*PAYLOAD_BITS +: PAYLOAD_BITS];
    assign dest[g] = dest_cfg[g*DW +: DW];
    assign credit_cnt[g*CW +: CW] = credit[g];
    assign elig[g] = vld_user2interface[g] && credit[g] != '0;
  end

  // first eligible port searching cyclically after the last granted one
  always_comb begin
    found = 1'b0;
    gnt = last;
    for (int k = 1; k <= NUM_OUT_PORTS; k++) begin
      if (!found && elig[(int'(last) + k) % NUM_OUT_PORTS]) begin
        found = 1'b1;
        gnt = IW'((int'(last) + k) % NUM_OUT_PORTS);
      end
    end
  end

  assign accept = !reset && !resend && (!out_vld || out_ready) && found;

  // single-cycle accept strobe to the granted port
  always_comb begin
    ack_interface2user = '0;
    if (accept) ack_interface2user[gnt] = 1'b1;
  end

  // credit return and consumption applied together, then saturated at buffer depth
  always_comb begin
    int s;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      s = int'(credit[i]) + (credit_ret[i] ? FREESPACE_UPDATE_SIZE : 0) - ((accept && gnt == IW'(i)) ? 1 : 0);
      credit_nxt[i] = s > int'(CMAX) ? CMAX : CW'(s);
    end
  end

  assign dout_leaf_interface2bft = (resend || !out_vld) ? '0 : {1'b1, out_reg};

  // output register, pointer, per-port credits and sequence numbers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld <= 1'b0;
      out_reg <= '0;
      last <= IW'(NUM_OUT_PORTS - 1);
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= CMAX;
        seq[i] <= '0;
      end
    end else begin
      if (accept) begin
        out_vld <= 1'b1;
        out_reg <= {dest[gnt], seq[gnt], payload[gnt]};
        last <= gnt;
      end else if (!resend && out_ready) begin
        out_vld <= 1'b0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        credit[i] <= credit_nxt[i];
        if (accept && gnt == IW'(i)) seq[i] <= seq[i] + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed checks of arbitration, credits, backpressure and resend
module tb_leaf_out_arbiter;
  localparam logic [8:0] D0 = {5'd1, 4'd4};
  localparam logic [8:0] D1 = {5'd3, 4'd2};

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] din;
  logic [1:0]  vld, ack, credit_ret;
  logic [17:0] dest_cfg;
  logic        out_ready, resend;
  logic [48:0] dout;
  logic [15:0] credit_cnt;
  int          checks = 0;
  int          errors = 0;
  int          s0, s1;

  always #5 clk = ~clk;

  leaf_out_arbiter dut (
    .clk(clk),
    .reset(reset),
    .din_leaf_user2interface(din),
    .vld_user2interface(vld),
    .ack_interface2user(ack),
    .dest_cfg(dest_cfg),
    .credit_ret(credit_ret),
    .out_ready(out_ready),
    .resend(resend),
    .dout_leaf_interface2bft(dout),
    .credit_cnt(credit_cnt)
  );

  function automatic logic [63:0] pkt(input logic [8:0] d, input logic [6:0] s, input logic [31:0] p);
    return 64'({1'b1, d, s, p});
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; vld = 2'b11; din = '0; credit_ret = '0;
    out_ready = 1'b1; resend = 1'b0; dest_cfg = {D1, D0};
    #1;
    chk("rst_ack", 64'(ack), 64'(2'b00));
    chk("rst_dout", 64'(dout), 64'(0));
    chk("rst_credit", 64'(credit_cnt), 64'(16'h8080));
    vld = 2'b00;
    tick;
    reset = 1'b0;
    din[63:32] = 32'hDEADBEEF; vld = 2'b10;
    #1 chk("t1_ack", 64'(ack), 64'(2'b10));
    tick; vld = 2'b00;
    #1;
    chk("t1_dout", 64'(dout), pkt(D1, 7'd0, 32'hDEADBEEF));
    chk("t1_credit1", 64'(credit_cnt[15:8]), 64'(127));
    chk("t1_ack_off", 64'(ack), 64'(0));
    tick;
    chk("t1_clear", 64'(dout), 64'(0));
    din = {32'hB0B0B0B0, 32'hA0A0A0A0}; vld = 2'b11; s0 = 0; s1 = 1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_ack", 64'(ack), (k % 2 == 0) ? 64'(1) : 64'(2));
      tick;
      if (k % 2 == 0) begin
        chk("rr_dout0", 64'(dout), pkt(D0, 7'(s0), 32'hA0A0A0A0)); s0++;
      end else begin
        chk("rr_dout1", 64'(dout), pkt(D1, 7'(s1), 32'hB0B0B0B0)); s1++;
      end
    end
    vld = 2'b00;
    tick;
    chk("rr_credit", 64'(credit_cnt), 64'({8'd125, 8'd126}));
    din[31:0] = 32'hC0C0C0C0; vld = 2'b01; out_ready = 1'b0;
    #1 chk("bp_ack", 64'(ack), 64'(1));
    tick; din[31:0] = 32'h11111111;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_noack", 64'(ack), 64'(0));
      chk("bp_hold", 64'(dout), pkt(D0, 7'd2, 32'hC0C0C0C0));
      tick;
    end
    out_ready = 1'b1;
    #1 chk("bp_resume_ack", 64'(ack), 64'(1));
    tick; vld = 2'b00;
    chk("bp_next", 64'(dout), pkt(D0, 7'd3, 32'h11111111));
    resend = 1'b1; din[63:32] = 32'h22222222; vld = 2'b10;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rs_dout", 64'(dout), 64'(0));
      chk("rs_ack", 64'(ack), 64'(0));
      tick;
    end
    resend = 1'b0;
    #1;
    chk("rs_reappear", 64'(dout), pkt(D0, 7'd3, 32'h11111111));
    chk("rs_ack_after", 64'(ack), 64'(2));
    tick; vld = 2'b00;
    chk("rs_next", 64'(dout), pkt(D1, 7'd3, 32'h22222222));
    din[31:0] = 32'h33333333; vld = 2'b01;
    for (int k = 0; k < 124; k++) begin
      #1 chk("drain_ack", 64'(ack), 64'(1));
      tick;
    end
    chk("drain_last", 64'(dout), pkt(D0, 7'd127, 32'h33333333));
    chk("drain_credit0", 64'(credit_cnt[7:0]), 64'(0));
    #1 chk("cr0_noack", 64'(ack), 64'(0));
    din[63:32] = 32'h44444444; vld = 2'b11;
    #1 chk("cr0_skip", 64'(ack), 64'(2));
    tick; vld = 2'b01;
    chk("cr0_p1", 64'(dout), pkt(D1, 7'd4, 32'h44444444));
    credit_ret = 2'b01;
    #1 chk("cr0_ret_noack", 64'(ack), 64'(0));
    tick; credit_ret = 2'b00;
    chk("cr0_ret_credit", 64'(credit_cnt[7:0]), 64'(64));
    #1 chk("cr0_resume", 64'(ack), 64'(1));
    tick; vld = 2'b00;
    chk("seq_wrap", 64'(dout), pkt(D0, 7'd0, 32'h33333333));
    chk("credit_63", 64'(credit_cnt[7:0]), 64'(63));
    credit_ret = 2'b01;
    tick; credit_ret = 2'b00;
    chk("credit_127", 64'(credit_cnt[7:0]), 64'(127));
    vld = 2'b01; credit_ret = 2'b01;
    #1 chk("sat_ack", 64'(ack), 64'(1));
    tick; vld = 2'b00; credit_ret = 2'b00;
    chk("sat_both", 64'(credit_cnt[7:0]), 64'(128));
    chk("sat_dout", 64'(dout), pkt(D0, 7'd1, 32'h33333333));
    credit_ret = 2'b01;
    tick; credit_ret = 2'b00;
    chk("sat_at_max", 64'(credit_cnt[7:0]), 64'(128));
    vld = 2'b01; out_ready = 1'b0;
    #1 chk("mr_ack", 64'(ack), 64'(1));
    tick;
    chk("mr_held", 64'(dout), pkt(D0, 7'd2, 32'h33333333));
    #2 reset = 1'b1;
    #1;
    chk("mr_dout", 64'(dout), 64'(0));
    chk("mr_ack0", 64'(ack), 64'(0));
    chk("mr_credit", 64'(credit_cnt), 64'(16'h8080));
    tick; tick;
    reset = 1'b0; vld = 2'b00; out_ready = 1'b1;
    #1;
    chk("mr_rel_ack", 64'(ack), 64'(0));
    chk("mr_rel_dout", 64'(dout), 64'(0));
    vld = 2'b01;
    #1 chk("mr_new_ack", 64'(ack), 64'(1));
    tick; vld = 2'b00;
    chk("mr_seq0", 64'(dout), pkt(D0, 7'd0, 32'h33333333));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
